// File: rtl/rx_frame_filter.sv
// Destination-address filter behind the frame reception FSM: classifies each finished
// frame, queues accepted headers for the host and keeps saturating statistics.
module rx_frame_filter #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [47:0]          cfg_station_mac,
    input  logic                 cfg_promisc,
    input  logic                 cfg_accept_bcast,
    input  logic                 cfg_accept_mcast,
    input  logic                 in_done,
    input  logic                 in_frame_valid,
    input  logic [47:0]          in_dest_mac,
    input  logic [47:0]          in_src_mac,
    input  logic [15:0]          in_eth_type,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [47:0]          out_dest_mac,
    output logic [47:0]          out_src_mac,
    output logic [15:0]          out_eth_type,
    output logic [1:0]           out_match,
    output logic                 fifo_full,
    input  logic                 cnt_clear,
    output logic [CNT_WIDTH-1:0] cnt_accepted,
    output logic [CNT_WIDTH-1:0] cnt_filtered,
    output logic [CNT_WIDTH-1:0] cnt_crc_err,
    output logic [CNT_WIDTH-1:0] cnt_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] CLS_UCAST   = 2'd0;
    localparam logic [1:0] CLS_BCAST   = 2'd1;
    localparam logic [1:0] CLS_MCAST   = 2'd2;
    localparam logic [1:0] CLS_PROMISC = 2'd3;

    localparam logic [AW-1:0]        PTR_ONE   = AW'(1);
    localparam logic [AW:0]          CNT_INC   = (AW + 1)'(1);
    localparam logic [AW:0]          DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] STAT_ONE  = CNT_WIDTH'(1);

    logic [47:0] dest_mem  [FIFO_DEPTH];
    logic [47:0] src_mem   [FIFO_DEPTH];
    logic [15:0] type_mem  [FIFO_DEPTH];
    logic [1:0]  match_mem [FIFO_DEPTH];

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_next;

    logic       is_bcast, is_mcast;
    logic       accept, crc_drop, filt_drop;
    logic [1:0] cls;
    logic       push, pop, overflow;

    assign is_bcast = &in_dest_mac;
    assign is_mcast = in_dest_mac[40] && !is_bcast;

    // First match wins; a disabled broadcast/multicast falls through to the promiscuous rule.
    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    always_comb begin
        accept    = 1'b0;
        crc_drop  = 1'b0;
        filt_drop = 1'b0;
        cls       = CLS_UCAST;
        if (in_done) begin
            if (!in_frame_valid) begin
                crc_drop = 1'b1;
            end else if (is_bcast && cfg_accept_bcast) begin
                accept = 1'b1;
                cls    = CLS_BCAST;
            end else if (is_mcast && cfg_accept_mcast) begin
                accept = 1'b1;
                cls    = CLS_MCAST;
            end else if (in_dest_mac == cfg_station_mac) begin
                accept = 1'b1;
                cls    = CLS_UCAST;
            end else if (cfg_promisc) begin
                accept = 1'b1;
                cls    = CLS_PROMISC;
            end else begin
                filt_drop = 1'b1;
            end
        end
    end

    assign pop      = out_valid && out_ready;
    assign push     = accept && (!fifo_full || pop);
    assign overflow = accept && !push;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_INC;
        end else if (pop && !push) begin
            count_next = count - CNT_INC;
        end
    end

    // NOTE: storage is reset so the head outputs read zero out of reset; it is only a few entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                dest_mem[i]  <= '0;
                src_mem[i]   <= '0;
                type_mem[i]  <= '0;
                match_mem[i] <= '0;
            end
        end else if (push) begin
            dest_mem[wr_ptr]  <= in_dest_mac;
            src_mem[wr_ptr]   <= in_src_mac;
            type_mem[wr_ptr]  <= in_eth_type;
            match_mem[wr_ptr] <= cls;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            fifo_full <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            count     <= count_next;
            out_valid <= (count_next != '0);
            fifo_full <= (count_next == DEPTH_CNT);
        end
    end

    assign out_dest_mac = dest_mem[rd_ptr];
    assign out_src_mac  = src_mem[rd_ptr];
    assign out_eth_type = type_mem[rd_ptr];
    assign out_match    = match_mem[rd_ptr];

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + STAT_ONE;
    endfunction

    // A clear wins over any increment on the same edge.
    always_ff @(posedge clk) begin
        if (rst || cnt_clear) begin
            cnt_accepted <= '0;
            cnt_filtered <= '0;
            cnt_crc_err  <= '0;
            cnt_overflow <= '0;
        end else begin
            if (push)      cnt_accepted <= sat_inc(cnt_accepted);
            if (filt_drop) cnt_filtered <= sat_inc(cnt_filtered);
            if (crc_drop)  cnt_crc_err  <= sat_inc(cnt_crc_err);
            if (overflow)  cnt_overflow <= sat_inc(cnt_overflow);
        end
    end

endmodule

// File: tb/tb_rx_frame_filter.sv
// Directed bench for rx_frame_filter: a default instance plus a 2-bit-counter instance
// sharing the same stimulus to reach counter saturation quickly.
module tb_rx_frame_filter;

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] cfg_station_mac;
    logic        cfg_promisc, cfg_accept_bcast, cfg_accept_mcast;
    logic        in_done, in_frame_valid;
    logic [47:0] in_dest_mac, in_src_mac;
    logic [15:0] in_eth_type;
    logic        out_ready, cnt_clear;

    logic        out_valid, fifo_full;
    logic [47:0] out_dest_mac, out_src_mac;
    logic [15:0] out_eth_type;
    logic [1:0]  out_match;
    logic [15:0] cnt_accepted, cnt_filtered, cnt_crc_err, cnt_overflow;

    logic        s_out_valid, s_fifo_full;
    logic [47:0] s_out_dest_mac, s_out_src_mac;
    logic [15:0] s_out_eth_type;
    logic [1:0]  s_out_match;
    logic [1:0]  s_cnt_accepted, s_cnt_filtered, s_cnt_crc_err, s_cnt_overflow;

    int total = 0;
    int bad   = 0;

    localparam logic [47:0] STATION = 48'h02_00_00_00_00_01;
    localparam logic [47:0] SRC     = 48'h00_11_22_33_44_55;
    localparam logic [47:0] BCAST   = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] MCAST   = 48'h01_00_5E_00_00_01;
    localparam logic [47:0] OTHER   = 48'h0A_00_00_00_00_99;

    rx_frame_filter #(.FIFO_DEPTH(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .cfg_station_mac(cfg_station_mac), .cfg_promisc(cfg_promisc),
        .cfg_accept_bcast(cfg_accept_bcast), .cfg_accept_mcast(cfg_accept_mcast),
        .in_done(in_done), .in_frame_valid(in_frame_valid),
        .in_dest_mac(in_dest_mac), .in_src_mac(in_src_mac), .in_eth_type(in_eth_type),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_dest_mac(out_dest_mac), .out_src_mac(out_src_mac),
        .out_eth_type(out_eth_type), .out_match(out_match), .fifo_full(fifo_full),
        .cnt_clear(cnt_clear), .cnt_accepted(cnt_accepted), .cnt_filtered(cnt_filtered),
        .cnt_crc_err(cnt_crc_err), .cnt_overflow(cnt_overflow)
    );

    rx_frame_filter #(.FIFO_DEPTH(4), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst),
        .cfg_station_mac(cfg_station_mac), .cfg_promisc(cfg_promisc),
        .cfg_accept_bcast(cfg_accept_bcast), .cfg_accept_mcast(cfg_accept_mcast),
        .in_done(in_done), .in_frame_valid(in_frame_valid),
        .in_dest_mac(in_dest_mac), .in_src_mac(in_src_mac), .in_eth_type(in_eth_type),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_dest_mac(s_out_dest_mac), .out_src_mac(s_out_src_mac),
        .out_eth_type(s_out_eth_type), .out_match(s_out_match), .fifo_full(s_fifo_full),
        .cnt_clear(cnt_clear), .cnt_accepted(s_cnt_accepted), .cnt_filtered(s_cnt_filtered),
        .cnt_crc_err(s_cnt_crc_err), .cnt_overflow(s_cnt_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drives one in_done pulse at a negedge; returns on the following negedge.
    task automatic frame(input logic valid, input logic [47:0] dest, input logic [15:0] etype);
        in_done        = 1'b1;
        in_frame_valid = valid;
        in_dest_mac    = dest;
        in_src_mac     = SRC;
        in_eth_type    = etype;
        @(negedge clk);
        in_done        = 1'b0;
    endtask

    task automatic expect_pop(input string tag, input logic [15:0] etype, input logic [1:0] cls);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_type"},  64'(out_eth_type), 64'(etype));
        check({tag, "_match"}, 64'(out_match), 64'(cls));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; cfg_station_mac = STATION; cfg_promisc = 1'b0;
        cfg_accept_bcast = 1'b0; cfg_accept_mcast = 1'b0;
        in_done = 1'b0; in_frame_valid = 1'b0; in_dest_mac = '0; in_src_mac = '0;
        in_eth_type = '0; out_ready = 1'b0; cnt_clear = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_full",  64'(fifo_full), 64'd0);
        check("rst_dest",  64'(out_dest_mac), 64'd0);
        check("rst_type",  64'(out_eth_type), 64'd0);
        check("rst_match", 64'(out_match), 64'd0);
        check("rst_acc",   64'(cnt_accepted), 64'd0);
        check("rst_ovf",   64'(cnt_overflow), 64'd0);

        // Unicast to own station
        frame(1'b1, STATION, 16'h0800);
        check("uc_valid", 64'(out_valid), 64'd1);
        check("uc_dest",  64'(out_dest_mac), 64'(STATION));
        check("uc_src",   64'(out_src_mac), 64'(SRC));
        check("uc_acc",   64'(cnt_accepted), 64'd1);
        expect_pop("uc", 16'h0800, 2'd0);
        check("uc_empty", 64'(out_valid), 64'd0);

        // Broadcast accepted, broadcast rejected, multicast, broadcast via promiscuous
        cfg_accept_bcast = 1'b1;
        frame(1'b1, BCAST, 16'h0806);
        cfg_accept_bcast = 1'b0;
        frame(1'b1, BCAST, 16'h0807);
        check("bc_filt", 64'(cnt_filtered), 64'd1);
        cfg_accept_mcast = 1'b1;
        frame(1'b1, MCAST, 16'h86DD);
        cfg_accept_mcast = 1'b0;
        cfg_promisc = 1'b1;
        frame(1'b1, BCAST, 16'h0808);
        cfg_promisc = 1'b0;
        check("cls_acc", 64'(cnt_accepted), 64'd4);
        expect_pop("bc", 16'h0806, 2'd1);
        expect_pop("mc", 16'h86DD, 2'd2);
        expect_pop("pr", 16'h0808, 2'd3);
        check("cls_empty", 64'(out_valid), 64'd0);

        // Bad CRC with matching destination
        frame(1'b0, STATION, 16'h0800);
        check("crc_cnt",   64'(cnt_crc_err), 64'd1);
        check("crc_valid", 64'(out_valid), 64'd0);
        check("crc_acc",   64'(cnt_accepted), 64'd4);

        // Fill to full and overflow by two
        for (int i = 1; i <= 6; i++) begin
            frame(1'b1, STATION, 16'(i));
            if (i == 3) check("fill3_full", 64'(fifo_full), 64'd0);
            if (i == 4) check("fill4_full", 64'(fifo_full), 64'd1);
        end
        check("ovf_acc", 64'(cnt_accepted), 64'd8);
        check("ovf_cnt", 64'(cnt_overflow), 64'd2);
        for (int i = 1; i <= 4; i++) expect_pop("drain", 16'(i), 2'd0);
        check("drain_empty", 64'(out_valid), 64'd0);
        check("drain_full",  64'(fifo_full), 64'd0);

        // Full FIFO with pop and push on the same edge
        for (int i = 0; i < 4; i++) frame(1'b1, STATION, 16'h0011 + 16'(i));
        out_ready = 1'b1;
        frame(1'b1, STATION, 16'h0015);
        out_ready = 1'b0;
        check("pp_ovf",  64'(cnt_overflow), 64'd2);
        check("pp_full", 64'(fifo_full), 64'd1);
        check("pp_acc",  64'(cnt_accepted), 64'd13);
        check("sat_acc", 64'(s_cnt_accepted), 64'd3);
        for (int i = 0; i < 4; i++) expect_pop("pp", 16'h0012 + 16'(i), 2'd0);
        check("pp_empty", 64'(out_valid), 64'd0);

        // Counter clear, then saturation of the 2-bit filtered counter
        cnt_clear = 1'b1;
        @(negedge clk);
        cnt_clear = 1'b0;
        check("clr_acc",  64'(cnt_accepted), 64'd0);
        check("clr_filt", 64'(cnt_filtered), 64'd0);
        for (int i = 0; i < 5; i++) frame(1'b1, OTHER, 16'h0900);
        check("filt_cnt",  64'(cnt_filtered), 64'd5);
        check("filt_sat",  64'(s_cnt_filtered), 64'd3);
        check("filt_qempty", 64'(out_valid), 64'd0);
        cnt_clear = 1'b1;
        frame(1'b0, STATION, 16'h0900);
        cnt_clear = 1'b0;
        check("clrw_crc",  64'(cnt_crc_err), 64'd0);
        check("clrw_filt", 64'(cnt_filtered), 64'd0);
        check("clrw_sat",  64'(s_cnt_filtered), 64'd0);
        check("clrw_ovf",  64'(cnt_overflow), 64'd0);

        // Reset mid-operation with two queued entries and a frame on the reset edge
        frame(1'b1, STATION, 16'h0031);
        frame(1'b1, STATION, 16'h0032);
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        in_done = 1'b1; in_frame_valid = 1'b1; in_dest_mac = STATION; in_eth_type = 16'h0033;
        @(negedge clk);
        rst = 1'b0; in_done = 1'b0;
        check("mrst_valid", 64'(out_valid), 64'd0);
        check("mrst_acc",   64'(cnt_accepted), 64'd0);
        frame(1'b1, STATION, 16'h0077);
        expect_pop("post_rst", 16'h0077, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
